// File: rtl/collider_pkg.sv
// Shared constants and channel state type for the invader bullet collider.
// Contents:
//   DEF_X_OFFSET   screen x of bullet bitmap column 0
//   DEF_INV_CENTER offset from invader x to its hit point
//   DEF_ANIM_STEP  explosion sweep increment per tick
//   DEF_ANIM_END   sweep value at or above which the explosion ends
//   chan_state_e   per-channel state {IDLE, ANIM}
package collider_pkg;

  localparam int unsigned DEF_X_OFFSET   = 43;
  localparam int unsigned DEF_INV_CENTER = 2;
  localparam int unsigned DEF_ANIM_STEP  = 2;
  localparam int unsigned DEF_ANIM_END   = 159;

  typedef enum logic {
    IDLE = 1'b0,
    ANIM = 1'b1
  } chan_state_e;

endpackage

// File: rtl/collision_anim_channel.sv
// One invader channel: hit-window compare against the shared scan column,
// IDLE/ANIM state machine and the tick-paced explosion sweep.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   i_tick        one-cycle animation tick from the shared divider
//   i_bullet      bullet bit at the current scan column
//   i_scan        current scan column
//   i_x           invader x coordinate
//   i_active      channel eligible for a hit
//   o_hit_c       combinational hit decision for this cycle
//   o_hit         registered one-cycle hit pulse
//   o_flag        channel in explosion
//   o_watch       explosion sweep position
//   o_coords      invader x latched at the hit
module collision_anim_channel
  import collider_pkg::*;
#(
  parameter int unsigned COORD_W    = 8,
  parameter int unsigned COL_W      = 7,
  parameter int unsigned X_OFFSET   = DEF_X_OFFSET,
  parameter int unsigned INV_CENTER = DEF_INV_CENTER,
  parameter int unsigned HIT_TOL    = 1,
  parameter int unsigned ANIM_STEP  = DEF_ANIM_STEP,
  parameter int unsigned ANIM_END   = DEF_ANIM_END
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_tick,
  input  logic               i_bullet,
  input  logic [COL_W-1:0]   i_scan,
  input  logic [COORD_W-1:0] i_x,
  input  logic               i_active,
  output logic               o_hit_c,
  output logic               o_hit,
  output logic               o_flag,
  output logic [COORD_W-1:0] o_watch,
  output logic [COORD_W-1:0] o_coords
);

  localparam int unsigned DW = COORD_W + 2;
  localparam int unsigned WW = COORD_W + 1;

  chan_state_e         r_state;
  logic                r_hit;
  logic                r_flag;
  logic [COORD_W-1:0]  r_watch;
  logic [COORD_W-1:0]  r_coords;

  logic signed [DW-1:0] w_d;
  logic                 w_in_window;
  logic                 w_hit;
  logic [WW-1:0]        w_step;
  logic [COORD_W-1:0]   w_hit_watch;

  // Signed distance from bullet screen x to the invader hit point; negative never hits.
  assign w_d = $signed(DW'(i_x)) + $signed(DW'(INV_CENTER))
             - $signed(DW'(i_scan)) - $signed(DW'(X_OFFSET));
  assign w_in_window = !w_d[DW-1] && (w_d <= $signed(DW'(HIT_TOL)));
  assign w_hit       = (r_state == IDLE) && i_active && i_bullet && w_in_window;

  // Sweep computed one bit wider so the end compare cannot wrap.
  assign w_step      = WW'(r_watch) + WW'(ANIM_STEP);
  assign w_hit_watch = (i_scan == '0) ? '0 : COORD_W'(i_scan) - COORD_W'(1);

  // Channel state machine with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_hit    <= 1'b0;
      r_flag   <= 1'b0;
      r_watch  <= '0;
      r_coords <= '0;
    end else begin
      r_hit <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            r_state  <= ANIM;
            r_hit    <= 1'b1;
            r_flag   <= 1'b1;
            r_coords <= i_x;
            r_watch  <= w_hit_watch;
          end
        end
        ANIM: begin
          if (i_tick) begin
            // Threshold compare (not equality) so any step/end parity still terminates.
            if (w_step >= WW'(ANIM_END)) begin
              r_state <= IDLE;
              r_flag  <= 1'b0;
              r_watch <= '0;
            end else begin
              r_watch <= w_step[COORD_W-1:0];
            end
          end
        end
      endcase
    end
  end

  assign o_hit_c  = w_hit;
  assign o_hit    = r_hit;
  assign o_flag   = r_flag;
  assign o_watch  = r_watch;
  assign o_coords = r_coords;

endmodule

// File: rtl/invader_bullet_collider.sv
// Bullet/invader collision checker: a shared free-running column scanner tests
// each bullet bitmap column against NUM_INV invader channels in parallel.
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   bullet_data       bullet bitmap, bit k = bullet in column k
//   x_invader         packed invader x, channel i at [i*COORD_W +: COORD_W]
//   inv_active        per-channel hit eligibility
//   collision_flag    per-channel explosion in progress
//   watch_coords      per-channel explosion sweep position
//   collision_coords  per-channel invader x latched at hit
//   hit_mask          one-cycle pulse of channels hit this cycle
//   hit_col           struck column, 0 when hit_mask is 0
//   scan_col          current scan column
module invader_bullet_collider
  import collider_pkg::*;
#(
  parameter int unsigned NUM_COLS   = 119,
  parameter int unsigned SCAN_LAST  = 116,
  parameter int unsigned NUM_INV    = 2,
  parameter int unsigned COORD_W    = 8,
  parameter int unsigned X_OFFSET   = DEF_X_OFFSET,
  parameter int unsigned INV_CENTER = DEF_INV_CENTER,
  parameter int unsigned HIT_TOL    = 1,
  parameter int unsigned ANIM_STEP  = DEF_ANIM_STEP,
  parameter int unsigned ANIM_END   = DEF_ANIM_END,
  parameter int unsigned TICK_DIV   = 25000000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_COLS-1:0]           bullet_data,
  input  logic [NUM_INV*COORD_W-1:0]    x_invader,
  input  logic [NUM_INV-1:0]            inv_active,
  output logic [NUM_INV-1:0]            collision_flag,
  output logic [NUM_INV*COORD_W-1:0]    watch_coords,
  output logic [NUM_INV*COORD_W-1:0]    collision_coords,
  output logic [NUM_INV-1:0]            hit_mask,
  output logic [$clog2(NUM_COLS)-1:0]   hit_col,
  output logic [$clog2(NUM_COLS)-1:0]   scan_col
);

  localparam int unsigned COL_W = $clog2(NUM_COLS);
  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [COL_W-1:0]   r_scan;
  logic [COL_W-1:0]   r_hit_col;
  logic [DIV_W-1:0]   r_div;
  logic               w_tick;
  logic               w_bullet_bit;
  logic [NUM_INV-1:0] w_hit_c;

  assign w_tick       = (r_div == DIV_W'(TICK_DIV - 1));
  assign w_bullet_bit = bullet_data[r_scan];

  // Scanner, tick divider and struck-column register; none of these pause.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_scan    <= '0;
      r_div     <= '0;
      r_hit_col <= '0;
    end else begin
      r_scan    <= (r_scan == COL_W'(SCAN_LAST)) ? '0 : r_scan + COL_W'(1);
      r_div     <= w_tick ? '0 : r_div + DIV_W'(1);
      r_hit_col <= (|w_hit_c) ? r_scan : '0;
    end
  end

  // One channel per invader, all fed the same scan column and tick.
  for (genvar gi = 0; gi < NUM_INV; gi++) begin : g_chan
    collision_anim_channel #(
      .COORD_W    (COORD_W),
      .COL_W      (COL_W),
      .X_OFFSET   (X_OFFSET),
      .INV_CENTER (INV_CENTER),
      .HIT_TOL    (HIT_TOL),
      .ANIM_STEP  (ANIM_STEP),
      .ANIM_END   (ANIM_END)
    ) u_chan (
      .clock    (clock),
      .reset    (reset),
      .i_tick   (w_tick),
      .i_bullet (w_bullet_bit),
      .i_scan   (r_scan),
      .i_x      (x_invader[gi*COORD_W +: COORD_W]),
      .i_active (inv_active[gi]),
      .o_hit_c  (w_hit_c[gi]),
      .o_hit    (hit_mask[gi]),
      .o_flag   (collision_flag[gi]),
      .o_watch  (watch_coords[gi*COORD_W +: COORD_W]),
      .o_coords (collision_coords[gi*COORD_W +: COORD_W])
    );
  end

  assign hit_col  = r_hit_col;
  assign scan_col = r_scan;

endmodule

// File: tb/tb_invader_bullet_collider.sv
// Directed bench: two instances (exact window and two-pixel window), both
// with a short tick divider, driven by the same stimulus.
module tb_invader_bullet_collider;

  logic         clock;
  logic         reset;
  logic [118:0] bullet_data;
  logic [15:0]  x_invader;
  logic [1:0]   inv_active;

  logic [1:0]  d0_flag, d0_hm, d1_flag, d1_hm;
  logic [15:0] d0_watch, d0_coords, d1_watch, d1_coords;
  logic [6:0]  d0_hc, d0_sc, d1_hc, d1_sc;

  int n_checks = 0;
  int n_fail   = 0;

  int p0, p1;
  logic [6:0] hc0, hc1;
  logic [7:0] w1, c1;

  invader_bullet_collider #(.HIT_TOL(0), .TICK_DIV(4)) u_dut0 (
    .clock(clock), .reset(reset), .bullet_data(bullet_data),
    .x_invader(x_invader), .inv_active(inv_active),
    .collision_flag(d0_flag), .watch_coords(d0_watch),
    .collision_coords(d0_coords), .hit_mask(d0_hm),
    .hit_col(d0_hc), .scan_col(d0_sc)
  );

  invader_bullet_collider #(.HIT_TOL(1), .TICK_DIV(4)) u_dut1 (
    .clock(clock), .reset(reset), .bullet_data(bullet_data),
    .x_invader(x_invader), .inv_active(inv_active),
    .collision_flag(d1_flag), .watch_coords(d1_watch),
    .collision_coords(d1_coords), .hit_mask(d1_hm),
    .hit_col(d1_hc), .scan_col(d1_sc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic set_bullets(input int a, input int b);
    bullet_data = '0;
    if (a >= 0) bullet_data[a] = 1'b1;
    if (b >= 0) bullet_data[b] = 1'b1;
  endtask

  task automatic run_cycles(input int n);
    p0 = 0; p1 = 0; hc0 = '0; hc1 = '0; w1 = '0; c1 = '0;
    for (int i = 0; i < n; i++) begin
      step();
      if (d0_hm != 2'b00) begin p0++; hc0 = d0_hc; end
      if (d1_hm != 2'b00) begin p1++; hc1 = d1_hc; w1 = d1_watch[7:0]; c1 = d1_coords[7:0]; end
    end
  endtask

  task automatic wait_scan(input int col);
    int n = 0;
    while (int'(d0_sc) != col && n < 300) begin
      step();
      n++;
    end
    chk("wait_scan_reached", 32'(d0_sc), 32'(col));
  endtask

  initial begin
    int extra, steps, bad, last_w, fs, cyc, n;
    logic [7:0] prev_w;

    reset       = 1'b1;
    bullet_data = '0;
    x_invader   = '0;
    inv_active  = 2'b00;
    step(); step(); step();

    // Reset state
    chk("rst_flag",   32'(d0_flag),   0);
    chk("rst_hm",     32'(d0_hm),     0);
    chk("rst_hc",     32'(d0_hc),     0);
    chk("rst_sc",     32'(d0_sc),     0);
    chk("rst_watch",  32'(d0_watch),  0);
    chk("rst_coords", 32'(d0_coords), 0);

    // Neighbour columns 18/20: exact window misses both, wide window hits 18 only
    do_reset();
    x_invader = {8'd0, 8'd60}; inv_active = 2'b01; set_bullets(18, 20);
    run_cycles(130);
    chk("exact_neighbours_nohit", 32'(p0), 0);
    chk("win_col18_pulses",       32'(p1), 1);
    chk("win_col18_hitcol",       32'(hc1), 18);
    chk("win_col18_watch",        32'(w1), 17);
    chk("win_col18_coords",       32'(c1), 60);

    // d=2 and d=-1 never hit
    do_reset();
    set_bullets(17, 20);
    run_cycles(130);
    chk("win_d2_dneg_nohit", 32'(p1), 0);
    chk("exact_d2_dneg_nohit", 32'(p0), 0);

    // Exact hit on column 19
    do_reset();
    set_bullets(19, -1);
    wait_scan(19);
    step();
    chk("exact_hm",     32'(d0_hm), 1);
    chk("exact_hc",     32'(d0_hc), 19);
    chk("exact_watch",  32'(d0_watch[7:0]), 18);
    chk("exact_coords", 32'(d0_coords[7:0]), 60);
    chk("exact_flag",   32'(d0_flag), 1);
    chk("win_col19_hm", 32'(d1_hm), 1);
    step();
    chk("pulse_ends_hm", 32'(d0_hm), 0);
    chk("pulse_ends_hc", 32'(d0_hc), 0);

    // Sweep from 18 to 158 in steps of 2, then clear; bullet stays set
    extra = 0; steps = 0; bad = 0; last_w = 18; fs = 0; cyc = 0;
    prev_w = 8'd18;
    for (int i = 0; i < 400; i++) begin
      step();
      cyc++;
      if (d0_hm != 2'b00) extra++;
      if (d0_flag[0] == 1'b0) break;
      if (d0_watch[7:0] != prev_w) begin
        if (steps == 0) fs = cyc;
        if (d0_watch[7:0] == prev_w + 8'd2) steps++; else bad++;
        prev_w = d0_watch[7:0];
        last_w = int'(prev_w);
      end
    end
    chk("sweep_cleared_flag", 32'(d0_flag[0]), 0);
    chk("sweep_clear_watch",  32'(d0_watch[7:0]), 0);
    chk("sweep_steps",        32'(steps), 70);
    chk("sweep_bad_steps",    32'(bad), 0);
    chk("sweep_last_watch",   32'(last_w), 158);
    chk("sweep_first_step_1to4", 32'((fs >= 1 && fs <= 4) ? 1 : 0), 1);
    chk("sweep_no_rehit",     32'(extra), 0);
    chk("sweep_coords_hold",  32'(d0_coords[7:0]), 60);

    // Simultaneous hit on both channels, then no re-hit during explosion
    do_reset();
    x_invader = {8'd60, 8'd60}; inv_active = 2'b11; set_bullets(19, -1);
    wait_scan(19);
    step();
    chk("dual_hm",     32'(d0_hm), 3);
    chk("dual_flag",   32'(d0_flag), 3);
    chk("dual_hc",     32'(d0_hc), 19);
    chk("dual_coords", 32'(d0_coords), 32'h3c3c);
    set_bullets(19, 18);
    run_cycles(200);
    chk("dual_no_rehit",   32'(p0), 0);
    chk("dual_flag_holds", 32'(d0_flag), 3);

    // Inactive channels never hit
    do_reset();
    x_invader = {8'd60, 8'd60}; inv_active = 2'b00; set_bullets(19, -1);
    run_cycles(130);
    chk("inactive_nohit", 32'(p0), 0);
    chk("inactive_flag",  32'(d0_flag), 0);

    // Column-0 hit saturates watch at 0; scan wraps 116 -> 0
    reset = 1'b1;
    x_invader = {8'd0, 8'd41}; inv_active = 2'b01; set_bullets(0, -1);
    step(); step();
    reset = 1'b0;
    step();
    chk("col0_hm",     32'(d0_hm), 1);
    chk("col0_hc",     32'(d0_hc), 0);
    chk("col0_watch",  32'(d0_watch[7:0]), 0);
    chk("col0_coords", 32'(d0_coords[7:0]), 41);
    chk("col0_sc",     32'(d0_sc), 1);
    wait_scan(116);
    step();
    chk("scan_wrap", 32'(d0_sc), 0);

    // Reset mid-explosion at watch 40
    do_reset();
    x_invader = {8'd0, 8'd60}; inv_active = 2'b01; set_bullets(19, -1);
    n = 0;
    while (d0_watch[7:0] != 8'd40 && n < 300) begin
      step();
      n++;
    end
    chk("mid_watch_reached", 32'(d0_watch[7:0]), 40);
    chk("mid_flag_set",      32'(d0_flag[0]), 1);
    reset = 1'b1;
    step();
    chk("mid_rst_flag",   32'(d0_flag), 0);
    chk("mid_rst_watch",  32'(d0_watch), 0);
    chk("mid_rst_coords", 32'(d0_coords), 0);
    chk("mid_rst_hm",     32'(d0_hm), 0);
    chk("mid_rst_sc",     32'(d0_sc), 0);
    reset = 1'b0;
    step();
    chk("mid_restart_sc", 32'(d0_sc), 1);
    chk("mid_restart_flag", 32'(d1_flag), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
